xalu: RTL and testbench

XALU -- requirements
Module: xalu

---
 rtl/xalu_pkg.sv | 43 ++++
 rtl/xalu.sv | 170 +++++++++++++++++
 tb/tb_xalu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/xalu_pkg.sv
// Shared CPU definitions for the HI/LO multiply-divide unit: op encodings,
// fixed latencies and small decode helpers used by controller and hazard logic.
package xalu_pkg;

    typedef enum logic [2:0] {
        XOP_NONE  = 3'b000,
        XOP_MULT  = 3'b001,
        XOP_MULTU = 3'b010,
        XOP_DIV   = 3'b011,
        XOP_DIVU  = 3'b100,
        XOP_MTHI  = 3'b101,
        XOP_MTLO  = 3'b110,
        XOP_RSVD  = 3'b111
    } xalu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } xalu_state_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    function automatic logic is_long_op(input xalu_op_e op);
        logic res;
        case (op)
            XOP_MULT, XOP_MULTU, XOP_DIV, XOP_DIVU: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] op_cycles(input xalu_op_e op);
        logic [3:0] res;
        case (op)
            XOP_MULT, XOP_MULTU: res = MULT_CYCLES;
            XOP_DIV, XOP_DIVU:   res = DIV_CYCLES;
            default:             res = 4'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/xalu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results come from latched operands and commit on the edge where Busy falls.
module xalu
    import xalu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  XALUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    xalu_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    xalu_op_e    op_q, op_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    xalu_op_e    op_in_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s, res_lo_s;
    logic        res_wr_s;

    assign op_in_s = xalu_op_e'(XALUOp);

    // Product/quotient/remainder of the latched operands.
    always_comb begin
        prod_s   = 64'd0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_wr_s = 1'b0;
        case (op_q)
            XOP_MULT: begin
                prod_s   = 64'($signed(a_q)) * 64'($signed(b_q));
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_wr_s = 1'b1;
            end
            XOP_MULTU: begin
                prod_s   = {32'd0, a_q} * {32'd0, b_q};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_wr_s = 1'b1;
            end
            XOP_DIV: begin
                if (b_q == 32'd0) begin
                    res_wr_s = 1'b0;
                end else if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
                    // Quotient overflows; wrap to the dividend with no trap.
                    res_lo_s = 32'h8000_0000;
                    res_hi_s = 32'd0;
                    res_wr_s = 1'b1;
                end else begin
                    res_lo_s = 32'($signed(a_q) / $signed(b_q));
                    res_hi_s = 32'($signed(a_q) % $signed(b_q));
                    res_wr_s = 1'b1;
                end
            end
            XOP_DIVU: begin
                if (b_q == 32'd0) begin
                    res_wr_s = 1'b0;
                end else begin
                    res_lo_s = a_q / b_q;
                    res_hi_s = a_q % b_q;
                    res_wr_s = 1'b1;
                end
            end
            default: res_wr_s = 1'b0;
        endcase
    end

    // Next-state, countdown and operand latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && is_long_op(op_in_s)) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op_in_s;
                    cnt_d   = op_cycles(op_in_s);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Busy and HI/LO next values: result commit and mthi/mtlo writes.
    always_comb begin
        busy_d = busy_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && is_long_op(op_in_s)) begin
                    busy_d = 1'b1;
                end else if ((op_in_s == XOP_MTHI) && !busy_q) begin
                    hi_d = A;
                end else if ((op_in_s == XOP_MTLO) && !busy_q) begin
                    lo_d = A;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if ((cnt_q <= 4'd1) && res_wr_s) begin
                    busy_d = 1'b0;
                    hi_d   = res_hi_s;
                    lo_d   = res_lo_s;
                end else if (cnt_q <= 4'd1) begin
                    busy_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    // State, operand and architectural register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= XOP_NONE;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_xalu.sv
// Directed scoreboard bench for xalu: expected HI/LO/latency pushed on issue,
// popped and compared when Busy falls.
module tb_xalu;
    import xalu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] A, B;
    logic [2:0]  XALUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;
    int   busy_cnt;

    xalu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .XALUOp (XALUOp),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step();
        if (Busy) busy_cnt++;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cycles = ecyc;
        sb_q.push_back(e);
        XALUOp = op; A = a; B = b; Start = 1'b1;
        step();
        Start = 1'b0; XALUOp = 3'b000;
        busy_cnt = Busy ? 1 : 0;
    endtask

    task automatic finish(input string tag);
        exp_t e;
        int   guard;
        guard = 0;
        while (Busy && guard < 40) begin
            tick();
            guard++;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
            chk({tag, "_hi"}, HI, e.hi);
            chk({tag, "_lo"}, LO, e.lo);
        end
    endtask

    task automatic mtx(input logic [2:0] op, input logic [31:0] a);
        XALUOp = op; A = a;
        step();
        XALUOp = 3'b000;
    endtask

    initial begin
        logic rebusy;
        vectors = 0; miscompares = 0; busy_cnt = 0;
        rst_n = 1'b0; A = 32'd0; B = 32'd0; XALUOp = 3'b000; Start = 1'b0;
        repeat (2) step();
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        rst_n = 1'b1;
        step();

        launch(XOP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        finish("mult_neg2x3");

        launch(XOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        finish("multu_max");

        launch(XOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        finish("div_neg7by2");

        launch(XOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        finish("div_overflow");

        launch(XOP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        finish("divu_100by7");

        mtx(XOP_MTHI, 32'h11);
        chk("mthi_hi", HI, 32'h11);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        mtx(XOP_MTLO, 32'h22);
        chk("mtlo_lo", LO, 32'h22);
        launch(XOP_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        finish("divu_by_zero");

        XALUOp = 3'b111; Start = 1'b1; A = 32'd9; B = 32'd9;
        step();
        chk("rsvd_start_busy", {31'd0, Busy}, 32'd0);
        XALUOp = 3'b000;
        step();
        Start = 1'b0;
        chk("none_start_busy", {31'd0, Busy}, 32'd0);
        chk("noop_hi", HI, 32'h11);
        chk("noop_lo", LO, 32'h22);

        // mtlo and second Start during a running mult, plus operand churn.
        launch(XOP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        XALUOp = 3'b110; A = 32'h55;
        tick();
        XALUOp = 3'b010; Start = 1'b1; A = 32'd7; B = 32'd9;
        tick();
        Start = 1'b0; XALUOp = 3'b000;
        finish("mult_3x4_ignored");
        rebusy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (Busy) rebusy = 1'b1;
        end
        chk("no_second_busy", {31'd0, rebusy}, 32'd0);

        // Reset in the middle of a div.
        mtx(XOP_MTHI, 32'h99);
        launch(XOP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_rel_hi", HI, 32'd0);
        chk("rst_rel_lo", LO, 32'd0);
        launch(XOP_MULT, 32'd2, 32'd2, 32'd0, 32'd4, 5);
        finish("mult_2x2_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
